// File: rtl/jtag_tap_pkg.sv
// Purpose: shared TAP state encoding and default instruction/IDCODE constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  localparam logic [4:0]  IR_IDCODE_DEF  = 5'h01;
  localparam logic [4:0]  IR_USER_DEF    = 5'h04;
  localparam logic [31:0] IDCODE_VAL_DEF = 32'h1000_0DB3;

endpackage

// File: rtl/jtag_tck_edge_detect.sv
// Purpose: synchronise TCK/TMS/TDI into clk_i and emit TCK rise/fall strobes.
// Latency: pin edge to strobe 2-3 clk (3-4 clk with JTAG_TCK_GLITCH_FILTER_EN).
// Backpressure: none; strobes are single-cycle and cannot be stalled.
//
// Ports: clk_i/rst_ni clock and async active-low reset; tck_i/tms_i/tdi_i raw
// pins; rise_o/fall_o one-clk TCK edge strobes; tms_o/tdi_o synchronised pin
// values aligned with the strobes.
// Macro JTAG_TCK_GLITCH_FILTER_EN: deeper chain, TCK must hold a level for two
// samples before an edge is reported, rejecting 1-clk glitches.
module jtag_tck_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic rise_o,
  output logic fall_o,
  output logic tms_o,
  output logic tdi_o
);

`ifdef JTAG_TCK_GLITCH_FILTER_EN
  localparam int unsigned SYNC_DEPTH = 4;
`else
  localparam int unsigned SYNC_DEPTH = 3;
`endif
  // TMS/TDI are taken one stage earlier than the deepest TCK stage so they
  // line up with the strobe; their final stage would never be read.
  localparam int unsigned DATA_DEPTH = SYNC_DEPTH - 1;

  // Index 0 is the first flop after the pin.
  logic [SYNC_DEPTH-1:0] tck_q;
  logic [DATA_DEPTH-1:0] tms_q;
  logic [DATA_DEPTH-1:0] tdi_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
    end else begin
      tck_q <= {tck_q[SYNC_DEPTH-2:0], tck_i};
      tms_q <= {tms_q[DATA_DEPTH-2:0], tms_i};
      tdi_q <= {tdi_q[DATA_DEPTH-2:0], tdi_i};
    end
  end

`ifdef JTAG_TCK_GLITCH_FILTER_EN
  // Two matching new samples against an old opposite sample.
  assign rise_o = tck_q[1] & tck_q[2] & ~tck_q[3];
  assign fall_o = ~tck_q[1] & ~tck_q[2] & tck_q[3];
`else
  assign rise_o = ~tck_q[2] & tck_q[1];
  assign fall_o = tck_q[2] & ~tck_q[1];
`endif

  assign tms_o = tms_q[DATA_DEPTH-1];
  assign tdi_o = tdi_q[DATA_DEPTH-1];

endmodule

// File: rtl/jtag_tap_oversampled_ctrl.sv
// Purpose: IEEE 1149.1 TAP (IR, BYPASS, IDCODE, one user DR) run from clk_i.
// Latency: TCK edge to FSM/TDO update 3-4 clk (4-5 clk with glitch filter).
// Backpressure: none; user_capture_o/user_update_o are one-clk fire-and-forget pulses.
//
// Ports: clk_i/rst_ni; tck_i/tms_i/tdi_i asynchronous JTAG pins; tdo_o/tdo_oe_o
// JTAG output and enable; tap_state_o current TAP state; ir_o active
// instruction; user_capture_data_i value captured into the user DR;
// user_capture_o/user_update_o handshake pulses; user_update_data_o user DR
// contents latched in Update-DR.
// Macro JTAG_TCK_GLITCH_FILTER_EN (in jtag_tck_edge_detect) enables TCK glitch rejection.
// Requires f(clk_i) >= 6 x f(TCK).
module jtag_tap_oversampled_ctrl
  import jtag_tap_pkg::*;
#(
  parameter int unsigned          IR_W       = 5,
  parameter int unsigned          USER_DR_W  = 32,
  parameter logic [31:0]          IDCODE_VAL = IDCODE_VAL_DEF,
  parameter logic [IR_W-1:0]      IR_IDCODE  = IR_IDCODE_DEF,
  parameter logic [IR_W-1:0]      IR_USER    = IR_USER_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tck_i,
  input  logic                 tms_i,
  input  logic                 tdi_i,
  output logic                 tdo_o,
  output logic                 tdo_oe_o,
  output tap_state_e           tap_state_o,
  output logic [IR_W-1:0]      ir_o,
  input  logic [USER_DR_W-1:0] user_capture_data_i,
  output logic                 user_capture_o,
  output logic                 user_update_o,
  output logic [USER_DR_W-1:0] user_update_data_o
);

  logic rise;
  logic fall;
  logic tms;
  logic tdi;

  jtag_tck_edge_detect u_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tck_i  (tck_i),
    .tms_i  (tms_i),
    .tdi_i  (tdi_i),
    .rise_o (rise),
    .fall_o (fall),
    .tms_o  (tms),
    .tdi_o  (tdi)
  );

  tap_state_e            state_q, state_d;
  logic [IR_W-1:0]       ir_shift_q;
  logic [IR_W-1:0]       ir_q;
  logic [31:0]           idcode_q;
  logic [USER_DR_W-1:0]  user_dr_q;
  logic [USER_DR_W-1:0]  user_update_data_q;
  logic                  bypass_q;
  logic                  tdo_q;
  logic                  tdo_oe_q;

  // Anything that is neither IDCODE nor USER falls through to bypass.
  logic sel_idcode;
  logic sel_user;
  logic dr_lsb;

  assign sel_idcode = (ir_q == IR_IDCODE);
  assign sel_user   = (ir_q == IR_USER);
  assign dr_lsb     = sel_idcode ? idcode_q[0] :
                      sel_user   ? user_dr_q[0] : bypass_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TEST_LOGIC_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    user_capture_o = 1'b0;
    user_update_o  = 1'b0;
    if (rise) begin
      user_capture_o = (state_q == CAPTURE_DR) && sel_user;
      user_update_o  = (state_q == UPDATE_DR)  && sel_user;
      case (state_q)
        TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state_d = tms ? SELECT_DR  : RUN_TEST_IDLE;
        SELECT_DR:        state_d = tms ? SELECT_IR  : CAPTURE_DR;
        CAPTURE_DR:       state_d = tms ? EXIT1_DR   : SHIFT_DR;
        SHIFT_DR:         state_d = tms ? EXIT1_DR   : SHIFT_DR;
        EXIT1_DR:         state_d = tms ? UPDATE_DR  : PAUSE_DR;
        PAUSE_DR:         state_d = tms ? EXIT2_DR   : PAUSE_DR;
        EXIT2_DR:         state_d = tms ? UPDATE_DR  : SHIFT_DR;
        UPDATE_DR:        state_d = tms ? SELECT_DR  : RUN_TEST_IDLE;
        SELECT_IR:        state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state_d = tms ? EXIT1_IR   : SHIFT_IR;
        SHIFT_IR:         state_d = tms ? EXIT1_IR   : SHIFT_IR;
        EXIT1_IR:         state_d = tms ? UPDATE_IR  : PAUSE_IR;
        PAUSE_IR:         state_d = tms ? EXIT2_IR   : PAUSE_IR;
        EXIT2_IR:         state_d = tms ? UPDATE_IR  : SHIFT_IR;
        UPDATE_IR:        state_d = tms ? SELECT_DR  : RUN_TEST_IDLE;
        default:          state_d = TEST_LOGIC_RESET;
      endcase
    end
  end

  // Register actions belong to the state being left on this rise strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ir_shift_q         <= '0;
      ir_q               <= IR_IDCODE;
      idcode_q           <= '0;
      user_dr_q          <= '0;
      user_update_data_q <= '0;
      bypass_q           <= 1'b0;
      tdo_q              <= 1'b0;
      tdo_oe_q           <= 1'b0;
    end else begin
      if (rise) begin
        case (state_q)
          TEST_LOGIC_RESET: ir_q <= IR_IDCODE;
          CAPTURE_IR:       ir_shift_q <= {{(IR_W-2){1'b0}}, 2'b01};
          SHIFT_IR:         ir_shift_q <= {tdi, ir_shift_q[IR_W-1:1]};
          UPDATE_IR:        ir_q <= ir_shift_q;
          CAPTURE_DR: begin
            if (sel_idcode)    idcode_q  <= IDCODE_VAL;
            else if (sel_user) user_dr_q <= user_capture_data_i;
            else               bypass_q  <= 1'b0;
          end
          SHIFT_DR: begin
            if (sel_idcode)    idcode_q  <= {tdi, idcode_q[31:1]};
            else if (sel_user) user_dr_q <= {tdi, user_dr_q[USER_DR_W-1:1]};
            else               bypass_q  <= tdi;
          end
          UPDATE_DR: begin
            if (sel_user) user_update_data_q <= user_dr_q;
          end
          default: ;
        endcase
      end
      // TDO moves only on the falling edge so the host samples a stable bit on rise.
      if (fall) begin
        tdo_q    <= (state_q == SHIFT_IR) ? ir_shift_q[0] : dr_lsb;
        tdo_oe_q <= (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
      end
    end
  end

  assign tap_state_o        = state_q;
  assign ir_o               = ir_q;
  assign tdo_o              = tdo_q;
  assign tdo_oe_o           = tdo_oe_q;
  assign user_update_data_o = user_update_data_q;

endmodule

// File: tb/tb_jtag_tap_oversampled_ctrl.sv
// Purpose: scoreboard bench for jtag_tap_oversampled_ctrl using directed JTAG scans.
// Latency: TCK is driven at 10 clk per period, well above the oversampling minimum.
// Backpressure: n/a (bench).
module tb_jtag_tap_oversampled_ctrl;
  import jtag_tap_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic        tck_i;
  logic        tms_i;
  logic        tdi_i;
  logic        tdo_o;
  logic        tdo_oe_o;
  tap_state_e  tap_state_o;
  logic [4:0]  ir_o;
  logic [31:0] user_capture_data_i;
  logic        user_capture_o;
  logic        user_update_o;
  logic [31:0] user_update_data_o;

  jtag_tap_oversampled_ctrl dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .tck_i               (tck_i),
    .tms_i               (tms_i),
    .tdi_i               (tdi_i),
    .tdo_o               (tdo_o),
    .tdo_oe_o            (tdo_oe_o),
    .tap_state_o         (tap_state_o),
    .ir_o                (ir_o),
    .user_capture_data_i (user_capture_data_i),
    .user_capture_o      (user_capture_o),
    .user_update_o       (user_update_o),
    .user_update_data_o  (user_update_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cap_cnt = 0;
  int upd_cnt = 0;

  logic        tdo_q[$];
  logic [31:0] upd_q[$];
  logic        upd_pend = 1'b0;
  logic [31:0] upd_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // TDO monitor: the host samples TDO on the TCK rise; every enabled bit must be expected.
  always @(posedge tck_i) begin
    if (tdo_oe_o) begin
      total++;
      if (tdo_q.size() == 0) begin
        bad++;
        $display("FAIL tdo_unexpected: tdo_oe_o=1 with no bit expected (tdo=%b)", tdo_o);
      end else begin
        logic e;
        e = tdo_q.pop_front();
        if (tdo_o !== e) begin
          bad++;
          $display("FAIL tdo_bit: got %b expected %b", tdo_o, e);
        end
      end
    end
  end

  // Handshake monitor: counts pulses; update data is valid the cycle after the pulse.
  always @(negedge clk_i) begin
    if (upd_pend) begin
      upd_pend = 1'b0;
      total++;
      if (user_update_data_o !== upd_exp) begin
        bad++;
        $display("FAIL user_update_data: got %h expected %h", user_update_data_o, upd_exp);
      end
    end
    if (user_capture_o) cap_cnt++;
    if (user_update_o) begin
      upd_cnt++;
      if (upd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL user_update_unexpected: pulse with data %h", user_update_data_o);
      end else begin
        upd_exp  = upd_q.pop_front();
        upd_pend = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tck_cycle(input logic tms, input logic tdi);
    @(negedge clk_i);
    tck_i = 1'b0;
    tms_i = tms;
    tdi_i = tdi;
    repeat (5) @(negedge clk_i);
    tck_i = 1'b1;
    repeat (4) @(negedge clk_i);
  endtask

  // RUN_TEST_IDLE -> load IR -> RUN_TEST_IDLE. Capture value is always 00001.
  task automatic shift_ir(input logic [4:0] val);
    logic [4:0] cap;
    cap = 5'b00001;
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tdo_q.push_back(cap[i]);
      tck_cycle(i == 4, val[i]);
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  // RUN_TEST_IDLE -> shift n DR bits -> update -> RUN_TEST_IDLE.
  task automatic shift_dr(input int n, input logic [31:0] din, input logic [31:0] dout);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tdo_q.push_back(dout[i]);
      tck_cycle(i == n - 1, din[i]);
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  initial begin
    int cap0;
    int upd0;
    logic [31:0] cdat;
    rst_ni = 1'b0;
    tck_i  = 1'b0;
    tms_i  = 1'b0;
    tdi_i  = 1'b0;
    user_capture_data_i = 32'hCAFE_F00D;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_state",   32'(tap_state_o), 32'hF);
    check("rst_ir",      32'(ir_o), 32'h01);
    check("rst_tdo",     32'(tdo_o), 32'h0);
    check("rst_tdo_oe",  32'(tdo_oe_o), 32'h0);
    check("rst_cap",     32'(user_capture_o), 32'h0);
    check("rst_upd",     32'(user_update_o), 32'h0);
    check("rst_upd_dat", user_update_data_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    // Five TMS=1 clocks keep/put the TAP in Test-Logic-Reset.
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    repeat (6) @(negedge clk_i);
    check("tlr_state",  32'(tap_state_o), 32'hF);
    check("tlr_ir",     32'(ir_o), 32'h01);
    check("tlr_tdo_oe", 32'(tdo_oe_o), 32'h0);

    // IDCODE readback straight out of reset.
    tck_cycle(1'b0, 1'b0);
    shift_dr(32, 32'h0, 32'h1000_0DB3);
    repeat (6) @(negedge clk_i);
    check("idcode_state", 32'(tap_state_o), 32'hC);
    check("idcode_oe",    32'(tdo_oe_o), 32'h0);

    // Unknown instruction -> bypass: in 1,0,1,1 out 0,1,0,1.
    shift_ir(5'h1F);
    repeat (6) @(negedge clk_i);
    check("ir_1f", 32'(ir_o), 32'h1F);
    shift_dr(4, 32'hD, 32'hA);
    check("no_cap_yet", 32'(cap_cnt), 32'd0);
    check("no_upd_yet", 32'(upd_cnt), 32'd0);

    // User DR capture/shift/update.
    shift_ir(5'h04);
    repeat (6) @(negedge clk_i);
    check("ir_user", 32'(ir_o), 32'h04);
    upd_q.push_back(32'h1234_5678);
    shift_dr(32, 32'h1234_5678, 32'hCAFE_F00D);
    repeat (6) @(negedge clk_i);
    check("user_cap_cnt", 32'(cap_cnt), 32'd1);
    check("user_upd_cnt", 32'(upd_cnt), 32'd1);
    check("user_upd_dat", user_update_data_o, 32'h1234_5678);

    // Static TCK: nothing moves.
    repeat (60) @(negedge clk_i);
    check("static_state", 32'(tap_state_o), 32'hC);
    check("static_cap",   32'(cap_cnt), 32'd1);
    check("static_upd",   32'(upd_cnt), 32'd1);

    // Reset in the middle of a 16-bit user shift.
    cdat = 32'hA5A5_3C3C;
    user_capture_data_i = cdat;
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tdo_q.push_back(cdat[i]);
      tck_cycle(1'b0, 1'b1);
    end
    @(negedge clk_i);
    tck_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_state",  32'(tap_state_o), 32'hF);
    check("mid_rst_ir",     32'(ir_o), 32'h01);
    check("mid_rst_tdo",    32'(tdo_o), 32'h0);
    check("mid_rst_oe",     32'(tdo_oe_o), 32'h0);
    check("mid_rst_updat",  user_update_data_o, 32'h0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    cap0 = cap_cnt;
    upd0 = upd_cnt;
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    repeat (6) @(negedge clk_i);
    check("mid_rst_cap_cnt", 32'(cap0), 32'd2);
    check("mid_rst_no_upd",  32'(upd_cnt - upd0), 32'd0);
    check("post_rst_state",  32'(tap_state_o), 32'hC);

    // One-clk TCK glitch with TMS=1 from Run-Test/Idle.
    @(negedge clk_i);
    tck_i = 1'b0;
    tms_i = 1'b1;
    repeat (8) @(negedge clk_i);
    tck_i = 1'b1;
    @(negedge clk_i);
    tck_i = 1'b0;
    repeat (10) @(negedge clk_i);
`ifdef JTAG_TCK_GLITCH_FILTER_EN
    check("glitch_state", 32'(tap_state_o), 32'hC);
`else
    check("glitch_state", 32'(tap_state_o), 32'h7);
`endif

    check("tdo_queue_empty", 32'(tdo_q.size()), 32'd0);
    check("upd_queue_empty", 32'(upd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
